cntdn_timer: RTL and testbench

//  Loadable down-counting timer with prescaler; the counterpart of the up counter.

---
 rtl/cntdn_timer.sv | 122 ++++++++++++
 tb/tb_cntdn_timer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cntdn_timer.sv
// Loadable down-counting timer: counts a preset value to zero, one step every DIV clocks,
// with pause/resume, a one-cycle done pulse and a sticky expired flag.
module cntdn_timer #(
    parameter int WIDTH = 16,
    parameter int DIV   = 1000,
    parameter int DIV_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] q,
    output logic             running,
    output logic             done,
    output logic             expired
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSE   = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

    logic [1:0]       state_r, state_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic [DIV_W-1:0] presc_r, presc_s;
    logic             done_r, done_s;
    logic             running_r, expired_r;
    logic             tick_s;

    assign tick_s = (presc_r == PRESC_LAST);

    // Next-state, count and prescaler decisions; load overrides everything but reset.
    always_comb begin
        state_s = state_r;
        q_s     = q_r;
        presc_s = presc_r;
        done_s  = 1'b0;
        if (load) begin
            q_s     = load_val;
            presc_s = {DIV_W{1'b0}};
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        if (q_r != {WIDTH{1'b0}}) begin
                            state_s = S_RUN;
                            presc_s = {DIV_W{1'b0}};
                        end else begin
                            state_s = S_EXPIRED;
                            done_s  = 1'b1;
                        end
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (tick_s) begin
                        presc_s = {DIV_W{1'b0}};
                        // q==0 cannot occur in RUN; treating it like q==1 guarantees no underflow.
                        if (q_r > WIDTH'(1)) begin
                            q_s     = q_r - WIDTH'(1);
                            state_s = pause ? S_PAUSE : S_RUN;
                        end else begin
                            q_s     = {WIDTH{1'b0}};
                            state_s = S_EXPIRED;
                            done_s  = 1'b1;
                        end
                    end else if (pause) begin
                        state_s = S_PAUSE;
                    end else begin
                        presc_s = presc_r + DIV_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        state_s = S_RUN;
                    end else begin
                        state_s = S_PAUSE;
                    end
                end
                S_EXPIRED: begin
                    q_s = {WIDTH{1'b0}};
                end
                default: begin
                    state_s = S_IDLE;
                    q_s     = {WIDTH{1'b0}};
                    presc_s = {DIV_W{1'b0}};
                end
            endcase
        end
    end

    // State and registered outputs; status flags track the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            q_r       <= {WIDTH{1'b0}};
            presc_r   <= {DIV_W{1'b0}};
            done_r    <= 1'b0;
            running_r <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            q_r       <= q_s;
            presc_r   <= presc_s;
            done_r    <= done_s;
            running_r <= (state_s == S_RUN);
            expired_r <= (state_s == S_EXPIRED);
        end
    end

    assign q       = q_r;
    assign running = running_r;
    assign done    = done_r;
    assign expired = expired_r;

endmodule

// File: tb/tb_cntdn_timer.sv
// Directed self-checking bench for cntdn_timer with DIV=4, DIV_W=2, WIDTH=8.
module tb_cntdn_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [7:0] q;
    logic       running;
    logic       done;
    logic       expired;

    int checks;
    int fails;
    int early;

    cntdn_timer #(.WIDTH(8), .DIV(4), .DIV_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .q        (q),
        .running  (running),
        .done     (done),
        .expired  (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eq, input logic er,
                           input logic ed, input logic ee);
        chk({tag, ".q"},       32'(q),       32'(eq));
        chk({tag, ".running"}, 32'(running), 32'(er));
        chk({tag, ".done"},    32'(done),    32'(ed));
        chk({tag, ".expired"}, 32'(expired), 32'(ee));
    endtask

    initial begin
        checks = 0; fails = 0; early = 0;
        reset = 1'b1; load = 1'b0; load_val = 8'd0; start = 1'b0; pause = 1'b0;
        step();
        step();
        chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // T1: load 3, start; q steps every 4 clocks, done exactly 12 clocks after start
        load = 1'b1; load_val = 8'd3; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk_all("t1_e0", 8'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("t1_q", 32'(q), 32'(3 - i / 4));
            chk("t1_done", 32'(done), 32'(i == 12));
            chk("t1_run", 32'(running), 32'(i < 12));
        end
        step();
        chk_all("t1_after", 8'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("t1_sticky", 8'd0, 1'b0, 1'b0, 1'b1);

        // T2: load 5, start at E0, pause at E6, resume at E15; pause and resume edges both hold the prescaler
        load = 1'b1; load_val = 8'd5; step(); load = 1'b0;
        chk_all("t2_load", 8'd5, 1'b0, 1'b0, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 1; i <= 5; i++) step();
        chk_all("t2_e5", 8'd4, 1'b1, 1'b0, 1'b0);
        pause = 1'b1; step(); pause = 1'b0;
        chk_all("t2_paused", 8'd4, 1'b0, 1'b0, 1'b0);
        start = 1'b1; pause = 1'b0;
        for (int i = 7; i <= 14; i++) begin
            start = 1'b0; pause = (i == 10);
            step();
        end
        pause = 1'b0;
        chk_all("t2_e14", 8'd4, 1'b0, 1'b0, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        chk_all("t2_resume", 8'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 16; i <= 29; i++) begin
            step();
            if (done) early++;
        end
        chk("t2_early_done", 32'(early), 32'd0);
        chk_all("t2_e29", 8'd1, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("t2_e30", 8'd0, 1'b0, 1'b1, 1'b1);

        // T3: load 0, start -> expired next edge, single done pulse
        load = 1'b1; load_val = 8'd0; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk_all("t3_e0", 8'd0, 1'b0, 1'b1, 1'b1);
        step();
        chk_all("t3_e1", 8'd0, 1'b0, 1'b0, 1'b1);

        // T4: start/pause ignored while expired; load leaves
        start = 1'b1; pause = 1'b1; step(); step(); start = 1'b0; pause = 1'b0;
        chk_all("t4_ignored", 8'd0, 1'b0, 1'b0, 1'b1);
        load = 1'b1; load_val = 8'd2; step(); load = 1'b0;
        chk_all("t4_load", 8'd2, 1'b0, 1'b0, 1'b0);

        // T5: load beats start on the same edge
        load = 1'b1; start = 1'b1; load_val = 8'd7; step(); load = 1'b0;
        chk_all("t5_same", 8'd7, 1'b0, 1'b0, 1'b0);
        step(); start = 1'b0;
        chk_all("t5_start", 8'd7, 1'b1, 1'b0, 1'b0);

        // T6a: reset mid-RUN at q=2
        load = 1'b1; load_val = 8'd3; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 1; i <= 5; i++) step();
        chk("t6a_pre_q", 32'(q), 32'd2);
        reset = 1'b1; step(); reset = 1'b0;
        chk_all("t6a_reset", 8'd0, 1'b0, 1'b0, 1'b0);

        // T6b: reset on the edge where q would go 1->0
        load = 1'b1; load_val = 8'd1; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 1; i <= 3; i++) step();
        chk_all("t6b_pre", 8'd1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1; step(); reset = 1'b0;
        chk_all("t6b_reset", 8'd0, 1'b0, 1'b0, 1'b0);
        early = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || expired) early++;
        end
        chk("t6b_no_done", 32'(early), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
